// File: rtl/latch_pkg.sv
// Shared types and default widths for the latch output conditioning stages.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package latch_pkg;

    // Debounce FSM: stable low/high plus a checking state for each direction.
    typedef enum logic [1:0] {
        S_LO     = 2'd0,
        S_CHK_HI = 2'd1,
        S_HI     = 2'd2,
        S_CHK_LO = 2'd3
    } state_e;

    localparam int DB_W_DEF  = 8;
    localparam int CNT_W_DEF = 16;
    localparam int TS_W_DEF  = 16;

endpackage

// File: rtl/latch_q_conditioner_if.sv
// Event record channel: one committed transition (level + timestamp) per transfer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the record is held while evt_valid=1 and evt_ready=0.
// Ports: evt_valid/evt_level/evt_ts driven by master, evt_ready driven by slave.
interface latch_q_conditioner_if #(
    parameter int TS_W = latch_pkg::TS_W_DEF
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic            evt_level;
    logic [TS_W-1:0] evt_ts;

    modport master (output evt_valid, output evt_level, output evt_ts, input evt_ready);
    modport slave  (input evt_valid, input evt_level, input evt_ts, output evt_ready);
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clk edges from d to q.
// Backpressure: none.
// Ports: clk, rstn (async active-low), d (async input), q (synchronized output).
module sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic ff1_q, ff1_d;
    logic ff2_q, ff2_d;

    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;
endmodule

// File: rtl/latch_q_conditioner.sv
// Synchronizes and debounces a latch output; emits edge pulses, a saturating
// transition count and a timestamped event record.
// Latency: q_in held from before edge k commits at edge k+1+N. Backpressure: a
// full, unaccepted record slot drops new records and sets sticky evt_lost.
// Ports: clk, rstn, q_in, cfg_db_cycles, clr_cnt, q_stable, rise_pulse,
// fall_pulse, toggle_cnt, cnt_ovf, evt_lost, evt (record channel, master).
module latch_q_conditioner
    import latch_pkg::*;
#(
    parameter int DB_W  = DB_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          q_in,
    input  logic [DB_W-1:0]               cfg_db_cycles,
    input  logic                          clr_cnt,
    output logic                          q_stable,
    output logic                          rise_pulse,
    output logic                          fall_pulse,
    output logic [CNT_W-1:0]              toggle_cnt,
    output logic                          cnt_ovf,
    output logic                          evt_lost,
    latch_q_conditioner_if.master         evt
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic sync;

    sync2 u_sync2 (
        .clk  (clk),
        .rstn (rstn),
        .d    (q_in),
        .q    (sync)
    );

    state_e            state_q, state_d;
    logic [DB_W-1:0]   dbc_q, dbc_d;
    logic              q_stable_q, q_stable_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              evt_valid_q, evt_valid_d;
    logic              evt_level_q, evt_level_d;
    logic [TS_W-1:0]   evt_ts_q, evt_ts_d;
    logic              lost_q, lost_d;

    logic [DB_W-1:0]   n_win;
    logic [DB_W:0]     dbc_inc;
    logic              commit;
    logic              new_level;
    logic              xfer;

    always_comb begin
        // A zero window would never commit; treat it as a single sample.
        n_win     = (cfg_db_cycles == '0) ? DB_W'(1) : cfg_db_cycles;
        // One extra bit so dbc+1 never wraps before the compare.
        dbc_inc   = {1'b0, dbc_q} + (DB_W+1)'(1);
        state_d   = state_q;
        dbc_d     = dbc_q;
        commit    = 1'b0;
        new_level = q_stable_q;

        unique case (state_q)
            S_LO: begin
                if (sync) begin
                    if (n_win == DB_W'(1)) begin
                        commit    = 1'b1;
                        new_level = 1'b1;
                        state_d   = S_HI;
                    end else begin
                        dbc_d   = DB_W'(1);
                        state_d = S_CHK_HI;
                    end
                end
            end
            S_CHK_HI: begin
                if (!sync) begin
                    dbc_d   = '0;
                    state_d = S_LO;
                end else if (dbc_inc >= {1'b0, n_win}) begin
                    commit    = 1'b1;
                    new_level = 1'b1;
                    dbc_d     = '0;
                    state_d   = S_HI;
                end else begin
                    dbc_d = dbc_inc[DB_W-1:0];
                end
            end
            S_HI: begin
                if (!sync) begin
                    if (n_win == DB_W'(1)) begin
                        commit    = 1'b1;
                        new_level = 1'b0;
                        state_d   = S_LO;
                    end else begin
                        dbc_d   = DB_W'(1);
                        state_d = S_CHK_LO;
                    end
                end
            end
            S_CHK_LO: begin
                if (sync) begin
                    dbc_d   = '0;
                    state_d = S_HI;
                end else if (dbc_inc >= {1'b0, n_win}) begin
                    commit    = 1'b1;
                    new_level = 1'b0;
                    dbc_d     = '0;
                    state_d   = S_LO;
                end else begin
                    dbc_d = dbc_inc[DB_W-1:0];
                end
            end
            default: begin
                state_d = S_LO;
                dbc_d   = '0;
            end
        endcase
    end

    always_comb begin
        q_stable_d = commit ? new_level : q_stable_q;
        rise_d     = commit & new_level;
        fall_d     = commit & ~new_level;
        ts_d       = ts_q + TS_W'(1);

        // A commit coinciding with a clear counts as the first transition.
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (commit) begin
            if (clr_cnt) begin
                cnt_d = CNT_W'(1);
                ovf_d = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clr_cnt) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end

        // Single-entry slot; a transfer frees it in time for a same-cycle commit.
        xfer        = evt_valid_q & evt.evt_ready;
        evt_valid_d = evt_valid_q;
        evt_level_d = evt_level_q;
        evt_ts_d    = evt_ts_q;
        // A drop in the same cycle as a clear still leaves evt_lost set.
        lost_d      = clr_cnt ? 1'b0 : lost_q;
        if (commit) begin
            if (!evt_valid_q || xfer) begin
                evt_valid_d = 1'b1;
                evt_level_d = new_level;
                evt_ts_d    = ts_q;
            end else begin
                lost_d = 1'b1;
            end
        end else if (xfer) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_LO;
            dbc_q       <= '0;
            q_stable_q  <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            ts_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_level_q <= 1'b0;
            evt_ts_q    <= '0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dbc_q       <= dbc_d;
            q_stable_q  <= q_stable_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            ts_q        <= ts_d;
            evt_valid_q <= evt_valid_d;
            evt_level_q <= evt_level_d;
            evt_ts_q    <= evt_ts_d;
            lost_q      <= lost_d;
        end
    end

    assign q_stable      = q_stable_q;
    assign rise_pulse    = rise_q;
    assign fall_pulse    = fall_q;
    assign toggle_cnt    = cnt_q;
    assign cnt_ovf       = ovf_q;
    assign evt_lost      = lost_q;
    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_level = evt_level_q;
    assign evt.evt_ts    = evt_ts_q;
endmodule

// File: tb/tb_latch_q_conditioner.sv
// Bench for latch_q_conditioner: two instances (16-bit and 2-bit counters)
// share stimulus; a run-length reference model is compared every cycle, and
// directed scenarios pin the model with hand-computed values.
module tb_latch_q_conditioner;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       q_in = 1'b0;
    logic [7:0] cfg = 8'd4;
    logic       clr_cnt = 1'b0;
    logic       evt_ready = 1'b0;

    always #5 clk = ~clk;

    latch_q_conditioner_if #(.TS_W(16)) if_a ();
    latch_q_conditioner_if #(.TS_W(16)) if_b ();
    assign if_a.evt_ready = evt_ready;
    assign if_b.evt_ready = evt_ready;

    logic        a_stable, a_rise, a_fall, a_ovf, a_lost;
    logic [15:0] a_cnt;
    logic        b_stable, b_rise, b_fall, b_ovf, b_lost;
    logic [1:0]  b_cnt;

    latch_q_conditioner #(.DB_W(8), .CNT_W(16), .TS_W(16)) dut_a (
        .clk(clk), .rstn(rstn), .q_in(q_in), .cfg_db_cycles(cfg), .clr_cnt(clr_cnt),
        .q_stable(a_stable), .rise_pulse(a_rise), .fall_pulse(a_fall),
        .toggle_cnt(a_cnt), .cnt_ovf(a_ovf), .evt_lost(a_lost), .evt(if_a.master)
    );

    latch_q_conditioner #(.DB_W(8), .CNT_W(2), .TS_W(16)) dut_b (
        .clk(clk), .rstn(rstn), .q_in(q_in), .cfg_db_cycles(cfg), .clr_cnt(clr_cnt),
        .q_stable(b_stable), .rise_pulse(b_rise), .fall_pulse(b_fall),
        .toggle_cnt(b_cnt), .cnt_ovf(b_ovf), .evt_lost(b_lost), .evt(if_b.master)
    );

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the synchronized sample is q_in delayed two edges; a
    // transition commits once N consecutive samples disagree with the level.
    bit m_h1 = 0, m_h2 = 0, m_stable = 0, m_rise = 0, m_fall = 0;
    int m_run = 0;
    int m_ts = 0;
    bit m_vld = 0, m_lvl = 0, m_lost = 0;
    int m_evts = 0;
    int m_cnt_a = 0, m_cnt_b = 0;
    bit m_ovf_a = 0, m_ovf_b = 0;
    bit s_smp, m_commit, m_xfer;
    int n_eff;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_h1 = 0; m_h2 = 0; m_stable = 0; m_rise = 0; m_fall = 0; m_run = 0;
            m_ts = 0; m_vld = 0; m_lvl = 0; m_lost = 0; m_evts = 0;
            m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 0; m_ovf_b = 0;
        end else begin
            s_smp = m_h2;
            m_h2  = m_h1;
            m_h1  = q_in;
            n_eff = (cfg == 0) ? 1 : int'(cfg);
            m_commit = 0;
            if (s_smp != m_stable) begin
                m_run++;
                if (m_run >= n_eff) begin
                    m_commit = 1;
                    m_stable = s_smp;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_rise = m_commit && s_smp;
            m_fall = m_commit && !s_smp;

            m_xfer = m_vld && evt_ready;
            if (clr_cnt) m_lost = 0;
            if (m_commit) begin
                if (!m_vld || m_xfer) begin
                    m_vld = 1; m_lvl = s_smp; m_evts = m_ts;
                end else begin
                    m_lost = 1;
                end
            end else if (m_xfer) begin
                m_vld = 0;
            end

            if (m_commit) begin
                if (clr_cnt) begin m_cnt_a = 1; m_ovf_a = 0; end
                else if (m_cnt_a == 65535) m_ovf_a = 1;
                else m_cnt_a++;
                if (clr_cnt) begin m_cnt_b = 1; m_ovf_b = 0; end
                else if (m_cnt_b == 3) m_ovf_b = 1;
                else m_cnt_b++;
            end else if (clr_cnt) begin
                m_cnt_a = 0; m_ovf_a = 0; m_cnt_b = 0; m_ovf_b = 0;
            end
            m_ts = (m_ts + 1) % 65536;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("m_stable_a", a_stable, m_stable);
            chk("m_rise_a", a_rise, m_rise);
            chk("m_fall_a", a_fall, m_fall);
            chk("m_cnt_a", a_cnt, m_cnt_a);
            chk("m_ovf_a", a_ovf, m_ovf_a);
            chk("m_lost_a", a_lost, m_lost);
            chk("m_vld_a", if_a.evt_valid, m_vld);
            chk("m_stable_b", b_stable, m_stable);
            chk("m_rise_b", b_rise, m_rise);
            chk("m_fall_b", b_fall, m_fall);
            chk("m_cnt_b", b_cnt, m_cnt_b);
            chk("m_ovf_b", b_ovf, m_ovf_b);
            chk("m_lost_b", b_lost, m_lost);
            chk("m_vld_b", if_b.evt_valid, m_vld);
            if (m_vld) begin
                chk("m_lvl_a", if_a.evt_level, m_lvl);
                chk("m_ts_a", if_a.evt_ts, m_evts);
                chk("m_lvl_b", if_b.evt_level, m_lvl);
                chk("m_ts_b", if_b.evt_ts, m_evts);
            end
        end
    end

    // After this returns, waiting k negedges lands just after edge k.
    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold;

    initial begin
        // Scenario 1: idle input, nothing happens.
        cfg = 8'd4; q_in = 1'b0; evt_ready = 1'b1;
        do_reset();
        run_chk = 1'b1;
        wait_n(20);
        chk("s1_stable", a_stable, 0);
        chk("s1_cnt", a_cnt, 0);
        chk("s1_valid", if_a.evt_valid, 0);
        chk("s1_lost", a_lost, 0);

        // Scenario 2: step before edge 10 with N=4 commits at edge 15, ts 14.
        evt_ready = 1'b0;
        do_reset();
        wait_n(9);
        q_in = 1'b1;
        wait_n(5);
        chk("s2_stable_early", a_stable, 0);
        wait_n(1);
        chk("s2_stable", a_stable, 1);
        chk("s2_rise", a_rise, 1);
        chk("s2_cnt", a_cnt, 1);
        chk("s2_valid", if_a.evt_valid, 1);
        chk("s2_level", if_a.evt_level, 1);
        chk("s2_ts", if_a.evt_ts, 14);
        wait_n(1);
        chk("s2_rise_gone", a_rise, 0);

        // Scenario 3: 3-cycle glitch rejected, 4-cycle pulse accepted.
        q_in = 1'b0; evt_ready = 1'b1;
        do_reset();
        wait_n(2);
        q_in = 1'b1; wait_n(3); q_in = 1'b0; wait_n(10);
        chk("s3_glitch_cnt", a_cnt, 0);
        q_in = 1'b1; wait_n(4); q_in = 1'b0; wait_n(12);
        chk("s3_pulse_cnt", a_cnt, 2);
        chk("s3_stable", a_stable, 0);

        // Scenario 4: cfg=0 acts as N=1; toggles after edges 4, 8, 12.
        cfg = 8'd0;
        do_reset();
        wait_n(4);
        for (int i = 0; i < 3; i++) begin
            q_in = ~q_in;
            wait_n(2);
            chk("s4_latency", a_stable, (i % 2 == 0) ? 0 : 1);
            wait_n(1);
            chk("s4_stable", a_stable, (i % 2 == 0) ? 1 : 0);
            chk("s4_rise", a_rise, (i % 2 == 0) ? 1 : 0);
            chk("s4_fall", a_fall, (i % 2 == 0) ? 0 : 1);
            chk("s4_level", if_a.evt_level, (i % 2 == 0) ? 1 : 0);
            chk("s4_ts", if_a.evt_ts, 4 + 4 * i + 2);
            wait_n(1);
        end
        q_in = 1'b0;

        // Scenario 5: backpressure holds the first record, second is lost.
        cfg = 8'd1; evt_ready = 1'b0;
        do_reset();
        wait_n(2); q_in = 1'b1;
        wait_n(4); q_in = 1'b0;
        wait_n(4);
        chk("s5_valid", if_a.evt_valid, 1);
        chk("s5_level", if_a.evt_level, 1);
        chk("s5_ts", if_a.evt_ts, 4);
        chk("s5_lost", a_lost, 1);
        chk("s5_cnt", a_cnt, 2);
        evt_ready = 1'b1;
        wait_n(1);
        chk("s5_drained", if_a.evt_valid, 0);
        evt_ready = 1'b0; clr_cnt = 1'b1;
        wait_n(1);
        clr_cnt = 1'b0;
        chk("s5_clr_cnt", a_cnt, 0);
        chk("s5_clr_lost", a_lost, 0);

        // Scenario 6: 5 transitions saturate the 2-bit counter; async reset mid-check.
        cfg = 8'd3; evt_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            q_in = ~q_in;
            wait_n(6);
        end
        chk("s6_cnt_a", a_cnt, 5);
        chk("s6_ovf_a", a_ovf, 0);
        chk("s6_cnt_b", b_cnt, 3);
        chk("s6_ovf_b", b_ovf, 1);
        q_in = 1'b0;
        wait_n(3);
        #2 rstn = 1'b0;
        #1;
        chk("s6_rst_stable", a_stable, 0);
        chk("s6_rst_cnt_a", a_cnt, 0);
        chk("s6_rst_cnt_b", b_cnt, 0);
        chk("s6_rst_ovf_b", b_ovf, 0);
        chk("s6_rst_valid", if_a.evt_valid, 0);

        // Random phase: model comparison carries the checking.
        for (int r = 0; r < 12; r++) begin
            cfg = 8'($urandom_range(0, 5));
            do_reset();
            hold = 0;
            for (int c = 0; c < 200; c++) begin
                if (hold == 0) begin
                    q_in = 1'($urandom_range(0, 1));
                    hold = $urandom_range(1, 8);
                end
                hold--;
                evt_ready = ($urandom_range(0, 3) != 0);
                clr_cnt   = ($urandom_range(0, 30) == 0);
                if (r % 3 == 1 && c == 100) begin
                    #2 rstn = 1'b0;
                    @(negedge clk);
                    #2 rstn = 1'b1;
                end
                @(negedge clk);
            end
            clr_cnt = 1'b0;
        end

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
